// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the LFSR / parity sequencing controller.
// The LFSR step and the tap-parity helper live here so the core and controller agree.
package lfsr_ctrl_pkg;

  localparam int unsigned LFSR_W = 4;

  // Taps for x^4 + x^3 + 1: feedback is q[3] ^ q[2].
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 4'b1100;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } lfsr_state_t;

  function automatic logic tap_parity(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], tap_parity(q)};
  endfunction

endpackage

// File: rtl/lfsr4_core.sv
// 4-bit Fibonacci shift register with synchronous load and step enable.
// Load has priority over enable.
module lfsr4_core
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] q_q;

  // Shift register state: load a seed or advance one step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= DEFAULT_SEED;
    end else if (load_i) begin
      q_q <= seed_i;
    end else if (en_i) begin
      q_q <= lfsr_next(q_q);
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lfsr_parity_ctrl.sv
// Bounded-run sequencer for the LFSR core with output-bit parity accumulation.
// Defining LFSR_PERIOD_CHECK_EN adds the wrap pulse and period_len capture.
module lfsr_parity_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned       STEP_W       = 5,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [STEP_W-1:0] n_steps,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [STEP_W-1:0] cnt,
  output logic              ris_pari_FF,
  output logic              wrap,
  output logic [STEP_W-1:0] period_len
);

  localparam logic [STEP_W-1:0] CNT_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] CNT_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  lfsr_state_t       state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              par_q, par_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lfsr_load_s;
  logic              lfsr_en_s;
  logic [STEP_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + CNT_ONE;

  lfsr4_core #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load_s),
    .en_i   (lfsr_en_s),
    .seed_i (seed_q),
    .q_o    (lfsr_q)
  );

  // Sequencing FSM, step counter and parity next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nsteps_d    = nsteps_q;
    seed_d      = seed_q;
    par_d       = par_q;
    lfsr_load_s = 1'b0;
    lfsr_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero seed would lock the LFSR up, so substitute the default.
          seed_d   = (seed == {LFSR_W{1'b0}}) ? DEFAULT_SEED : seed;
          nsteps_d = n_steps;
          state_d  = SEED;
        end else begin
          state_d  = IDLE;
        end
      end
      SEED: begin
        lfsr_load_s = 1'b1;
        cnt_d       = CNT_ZERO;
        par_d       = 1'b0;
        if (nsteps_q == CNT_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        par_d     = par_q ^ lfsr_q[LFSR_W-1];
        lfsr_en_s = 1'b1;
        cnt_d     = cnt_inc_s;
        if (cnt_inc_s == nsteps_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SEED) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      nsteps_q <= CNT_ZERO;
      seed_q   <= DEFAULT_SEED;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nsteps_q <= nsteps_d;
      seed_q   <= seed_d;
      par_q    <= par_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt         = cnt_q;
  assign ris_pari_FF = par_q;

`ifdef LFSR_PERIOD_CHECK_EN
  logic              wrap_q, wrap_d;
  logic [STEP_W-1:0] plen_q, plen_d;

  // Detect a shift that returns the LFSR to the loaded seed; keep the first count.
  always_comb begin
    wrap_d = 1'b0;
    plen_d = plen_q;
    if (state_q == SEED) begin
      plen_d = CNT_ZERO;
    end else if ((state_q == RUN) && (lfsr_next(lfsr_q) == seed_q)) begin
      wrap_d = 1'b1;
      if (plen_q == CNT_ZERO) begin
        plen_d = cnt_inc_s;
      end else begin
        plen_d = plen_q;
      end
    end else begin
      plen_d = plen_q;
    end
  end

  // Wrap pulse and captured period length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      plen_q <= CNT_ZERO;
    end else begin
      wrap_q <= wrap_d;
      plen_q <= plen_d;
    end
  end

  assign wrap       = wrap_q;
  assign period_len = plen_q;
`else
  assign wrap       = 1'b0;
  assign period_len = CNT_ZERO;
`endif

endmodule

// File: tb/tb_lfsr_parity_ctrl.sv
// Directed bench for lfsr_parity_ctrl; expectations are hand-computed LFSR sequences.
// Honours LFSR_PERIOD_CHECK_EN for the wrap/period_len expectations.
module tb_lfsr_parity_ctrl;

  localparam int STEP_W = 5;
`ifdef LFSR_PERIOD_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        seed = 4'd0;
  logic [STEP_W-1:0] n_steps = 5'd0;
  logic              busy, done, ris_pari_FF, wrap;
  logic [3:0]        lfsr_q;
  logic [STEP_W-1:0] cnt, period_len;

  int checks = 0;
  int errors = 0;
  logic [3:0] lfsr_log [0:63];
  int lat, busy_cnt, wrap_cnt, wrap_at;

  always #5 clk = ~clk;

  lfsr_parity_ctrl #(.STEP_W(STEP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .n_steps     (n_steps),
    .busy        (busy),
    .done        (done),
    .lfsr_q      (lfsr_q),
    .cnt         (cnt),
    .ris_pari_FF (ris_pari_FF),
    .wrap        (wrap),
    .period_len  (period_len)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run; negedge k after start's capture edge is logged in lfsr_log[k].
  task automatic run(input logic [3:0] s, input logic [STEP_W-1:0] n, input bit spam);
    @(negedge clk);
    start = 1'b1; seed = s; n_steps = n;
    @(posedge clk);
    #1;
    start = 1'b0; seed = ~s; n_steps = ~n;
    lat = 99; busy_cnt = 0; wrap_cnt = 0; wrap_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      lfsr_log[k] = lfsr_q;
      if (busy) busy_cnt++;
      if (wrap) begin wrap_cnt++; wrap_at = k; end
      if (spam && k >= 2 && k <= 4) begin
        start = 1'b1; seed = 4'b1000; n_steps = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit found;
    int dseen;
    // reset values
    repeat (2) @(negedge clk);
    check("rst_lfsr", {28'd0, lfsr_q}, 32'h1);
    check("rst_cnt", {27'd0, cnt}, 32'd0);
    check("rst_par", {31'd0, ris_pari_FF}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_plen", {27'd0, period_len}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // short run: seed 0001, 4 steps
    run(4'b0001, 5'd4, 1'b0);
    check("short_lat", lat, 6);
    check("short_load", {28'd0, lfsr_log[2]}, 32'h1);
    check("short_s1", {28'd0, lfsr_log[3]}, 32'h2);
    check("short_s2", {28'd0, lfsr_log[4]}, 32'h4);
    check("short_s3", {28'd0, lfsr_log[5]}, 32'h9);
    check("short_s4", {28'd0, lfsr_log[6]}, 32'h3);
    check("short_busy", busy_cnt, 5);
    check("short_cnt", {27'd0, cnt}, 32'd4);
    check("short_par", {31'd0, ris_pari_FF}, 32'd1);
    check("short_wrap", wrap_cnt, 0);

    // full period
    run(4'b0001, 5'd15, 1'b0);
    check("full_lat", lat, 17);
    check("full_lfsr", {28'd0, lfsr_q}, 32'h1);
    check("full_cnt", {27'd0, cnt}, 32'd15);
    check("full_par", {31'd0, ris_pari_FF}, 32'd0);
    check("full_wrap_cnt", wrap_cnt, PC ? 1 : 0);
    check("full_wrap_at", wrap_at, PC ? 17 : 0);
    check("full_plen", {27'd0, period_len}, PC ? 32'd15 : 32'd0);

    // zero seed substitutes the default seed
    run(4'b0000, 5'd1, 1'b0);
    check("zseed_lat", lat, 3);
    check("zseed_load", {28'd0, lfsr_log[2]}, 32'h1);
    check("zseed_lfsr", {28'd0, lfsr_q}, 32'h2);
    check("zseed_par", {31'd0, ris_pari_FF}, 32'd0);
    check("zseed_plen", {27'd0, period_len}, 32'd0);

    // zero steps
    run(4'b0110, 5'd0, 1'b0);
    check("zstep_lat", lat, 2);
    check("zstep_busy", busy_cnt, 1);
    check("zstep_cnt", {27'd0, cnt}, 32'd0);
    check("zstep_lfsr", {28'd0, lfsr_q}, 32'h6);

    // start re-asserted mid-run must be ignored
    run(4'b0001, 5'd4, 1'b1);
    check("lock_lat", lat, 6);
    check("lock_lfsr", {28'd0, lfsr_q}, 32'h3);
    check("lock_cnt", {27'd0, cnt}, 32'd4);
    check("lock_par", {31'd0, ris_pari_FF}, 32'd1);
    repeat (3) @(negedge clk);
    check("lock_no_queue", {31'd0, busy}, 32'd0);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; seed = 4'b0001; n_steps = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cnt == 5'd7) begin found = 1'b1; break; end
    end
    check("mid_reach7", {31'd0, found}, 32'd1);
    check("mid_lfsr_pre", {28'd0, lfsr_q}, 32'ha);
    rst = 1'b0;
    #1;
    check("mid_lfsr", {28'd0, lfsr_q}, 32'h1);
    check("mid_cnt", {27'd0, cnt}, 32'd0);
    check("mid_par", {31'd0, ris_pari_FF}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_plen", {27'd0, period_len}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dseen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    check("mid_idle_after", dseen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_parity_ctrl.md
# lfsr_parity_ctrl

Sequencing controller for the 4-bit LFSR / parity-flip-flop datapath. On a start request it:
- loads a seed into the LFSR;
- steps the LFSR a programmed number of clock cycles;
- accumulates the parity of the output bitstream into `ris_pari_FF`;
- reports completion with a one-cycle `done` pulse.

It sits between test/firmware control and the LFSR core, and replaces free-running operation with bounded, repeatable runs.

## Interface
Parameters:
- `STEP_W`, 5: width of step count and counter (max run 2^STEP_W−1 steps).
- `DEFAULT_SEED`, 4'b0001: substituted when `seed` = 0 (lock-up state).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE only.
- `seed`  in  4  initial LFSR state, captured with `start`.
- `n_steps`  in  STEP_W  number of LFSR shifts, captured with `start`.
- `busy`  out  1  high in SEED and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `lfsr_q`  out  4  current LFSR state.
- `cnt`  out  STEP_W  shifts performed in current/last run.
- `ris_pari_FF`  out  1  XOR of `lfsr_q[3]` sampled before each shift.
- `wrap`  out  1  pulse when the LFSR returns to the loaded seed (see Configuration).
- `period_len`  out  STEP_W  `cnt` value at the first wrap (see Configuration).

## Operation
- **LFSR:** Fibonacci, polynomial x^4+x^3+1.
  - Next state = {q[2:0], q[3]^q[2]}; maximal period 15.
- **FSM states:** IDLE, SEED, RUN, DONE.
- **IDLE:** outputs hold the last run's results.
  - `start` = 1 captures `seed` and `n_steps` → SEED.
- **SEED:**
  - `lfsr_q` ← seed, or `DEFAULT_SEED` if seed = 0.
  - `cnt` ← 0, `ris_pari_FF` ← 0.
  - Next state: DONE if `n_steps` = 0, else RUN.
- **RUN:** each cycle:
  - `ris_pari_FF` ^= `lfsr_q[3]`;
  - LFSR shifts;
  - `cnt`++.
  - When `cnt` + 1 = `n_steps` on the current edge → DONE.
- **DONE:** `done` = 1 → IDLE.
- `start` is ignored in SEED, RUN and DONE; no queuing.
- `cnt` never wraps: `n_steps` ≤ 2^STEP_W−1.
- Seed/step inputs may change freely after capture.
- Reset (any state, including mid-run):
  - state IDLE;
  - `lfsr_q` = `DEFAULT_SEED`;
  - `cnt` = 0, `ris_pari_FF` = 0;
  - `busy` = 0, `done` = 0, `wrap` = 0, `period_len` = 0.

## Timing
- `start` sampled at edge E0.
- SEED load occurs at E1.
- Shifts occur at E2 … E(N+1).
- `done` is high during the cycle after E(N+1) and falls at E(N+2).
- Total `start`-to-`done` latency: N+2 cycles. For N = 0, `done` rises after E1.
- `busy` is high from after E0 until E(N+1) inclusive; it is low while `done` = 1.
- Back-to-back runs: the earliest accepted `start` is in the IDLE cycle following DONE (period N+3).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `LFSR_PERIOD_CHECK_EN`.
- **Defined:**
  - During RUN, an edge whose shift produces `lfsr_q` equal to the loaded seed pulses `wrap` for one cycle.
  - The first such event in a run stores the post-increment `cnt` into `period_len`.
  - `period_len` is cleared in SEED.
- **Undefined:** `wrap` and `period_len` are tied to 0; the comparator and register are not synthesized.

## Structure
- Package `lfsr_ctrl_pkg` contains:
  - state enum `lfsr_state_t` (IDLE/SEED/RUN/DONE);
  - `LFSR_W` = 4;
  - tap constant (bits 3,2);
  - `DEFAULT_SEED` default value.
- Sub-module `lfsr4_core` (load, enable, seed in, q out) holds the shift register.
- The controller holds the FSM, counter, parity flip-flop and optional period check.

## Test plan
- **Reset mid-run:** `rst` low while `cnt` = 7 → all outputs return to reset values immediately, state IDLE; no `done`.
- **Short run:** `seed` = 0001, `n_steps` = 4.
  - `lfsr_q` sequence: 0010, 0100, 1001, 0011.
  - Final `cnt` = 4, `ris_pari_FF` = 1.
  - `done` appears 6 cycles after `start`.
- **Full period:** `seed` = 0001, `n_steps` = 15.
  - `lfsr_q` returns to 0001, `ris_pari_FF` = 0.
  - With the macro defined: `wrap` pulses at step 15 and `period_len` = 15.
- **Zero seed:** `seed` = 0000, `n_steps` = 1 → loads 0001, then `lfsr_q` = 0010, `ris_pari_FF` = 0.
- **Zero steps:** `n_steps` = 0 → `done` 2 cycles after `start`, `cnt` = 0, `lfsr_q` = seed.
- **Busy lockout:** `start` re-asserted during RUN with a different seed → ignored, results match the original run; the next run is accepted only after DONE.
